// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 4-bit LFSR pattern generator.
// Self-synchronises to the incoming sequence, then predicts each following
// word and counts mismatches in a saturating counter.
//
// Handshake: a word is consumed on every rising edge where valid_i=1; there is
// no back-pressure. On valid_i=0 cycles, no state, prediction or counter moves,
// and err_o reads 0 on the following cycle. clear_i is sampled on every cycle,
// independent of valid_i.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int LW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  logic [1:0]    state;
  logic [3:0]    pred;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic          err_hit;

  // Generator next-word rule.
  function automatic logic [3:0] nxt(input logic [3:0] cur);
    return {cur[2:0], cur[3] ^ cur[1]};
  endfunction

  // A counted error: a valid word that disagrees with the prediction while locked.
  always_comb begin
    err_hit = valid_i && (state == ST_LOCKED) && (data_i != pred);
  end

  // Sync FSM: hunt for a nonzero seed, verify LOCK_CNT follow-ups, then free-run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HUNT;
      pred      <= 4'h0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (valid_i) begin
        case (state)
          ST_HUNT: begin
            // Zero is the LFSR lock-up value and never seeds the prediction.
            if (data_i != 4'h0) begin
              pred      <= nxt(data_i);
              match_cnt <= '0;
              state     <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (data_i == pred) begin
              pred <= nxt(pred);
              if (match_cnt == LOCK_LAST) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                state     <= ST_LOCKED;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (data_i == 4'h0) begin
              match_cnt <= '0;
              state     <= ST_HUNT;
            end else begin
              // Reseed from the received word and restart verification.
              pred      <= nxt(data_i);
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Prediction free-runs so a corrupted word never disturbs it.
            pred <= nxt(pred);
            if (data_i != pred) begin
              err_o <= 1'b1;
              if (miss_cnt == LOSS_LAST) begin
                miss_cnt <= '0;
                state    <= ST_HUNT;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves one count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_o <= '0;
    end else if (clear_i) begin
      err_cnt_o <= err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && (err_cnt_o != {ERR_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  assign locked_o = (state == ST_LOCKED);
  assign state_o  = state;

endmodule
